// File: rtl/commit_trace_unit.sv
// Commit trace unit: classifies retired instructions into trace records queued in a FIFO; COMMIT_TRACE_WATCHDOG_EN adds a watchdog/TIMEOUT state.
// Latency: an accepted record reaches the FIFO head one cycle later when the FIFO was empty.
// Backpressure: trace_valid_o/trace_ready_i handshake; commits that find the FIFO full (with no pop) are dropped and counted.

module ctu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [WIDTH-1:0]       in_dat,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [WIDTH-1:0]       out_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign out_vld = (count != '0);
  assign pop     = out_vld && out_rdy;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign in_rdy  = (count != FULL_CNT) || pop;
  assign push    = in_vld && in_rdy;
  // Storage is not reset, so the head is masked to zero while empty.
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end
endmodule

module commit_trace_unit #(
  parameter int          XLEN           = 32,
  parameter int          DEPTH          = 16,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter logic [31:0] END_INSTR      = 32'h0000006f
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              instr_i,
  input  logic [4:0]               rd_addr_i,
  input  logic [XLEN-1:0]          rd_data_i,
  input  logic                     rd_we_i,
  input  logic                     mem_re_i,
  input  logic                     mem_we_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_wdata_i,
  input  logic [1:0]               mem_size_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [1:0]               trace_kind_o,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [31:0]              trace_instr_o,
  output logic [4:0]               trace_rd_o,
  output logic [XLEN-1:0]          trace_data_o,
  output logic [XLEN-1:0]          trace_addr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              drop_cnt_o,
  output logic                     overflow_o,
  output logic                     done_o,
  output logic                     timeout_o
);
  localparam logic [1:0] KIND_PLAIN = 2'd0;
  localparam logic [1:0] KIND_REG   = 2'd1;
  localparam logic [1:0] KIND_LOAD  = 2'd2;
  localparam logic [1:0] KIND_STORE = 2'd3;

  typedef struct packed {
    logic [1:0]      kind;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] addr;
  } trace_rec_t;

`ifdef COMMIT_TRACE_WATCHDOG_EN
  typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_TIMEOUT} state_e;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wdog;
`else
  typedef enum logic {ST_RUN, ST_DONE} state_e;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  state_e     state;
  trace_rec_t rec;
  trace_rec_t head;
  logic       accept;
  logic       fifo_rdy;
  logic       drop;

  always_comb begin
    rec       = '0;
    rec.kind  = KIND_PLAIN;
    rec.pc    = pc_i;
    rec.instr = instr_i;
    if (mem_we_i) begin
      rec.kind = KIND_STORE;
      rec.addr = mem_addr_i;
      case (mem_size_i)
        2'd0:    rec.data = {{(XLEN-8){1'b0}}, mem_wdata_i[7:0]};
        2'd1:    rec.data = {{(XLEN-16){1'b0}}, mem_wdata_i[15:0]};
        default: rec.data = mem_wdata_i;
      endcase
    end else if (mem_re_i && (rd_addr_i != 5'd0)) begin
      rec.kind = KIND_LOAD;
      rec.rd   = rd_addr_i;
      rec.data = rd_data_i;
      rec.addr = mem_addr_i;
    end else if (rd_we_i && (rd_addr_i != 5'd0)) begin
      rec.kind = KIND_REG;
      rec.rd   = rd_addr_i;
      rec.data = rd_data_i;
    end
  end

  assign accept = commit_valid_i && (pc_i != '0) && (state == ST_RUN);
  assign drop   = accept && !fifo_rdy;

  ctu_fifo #(
    .WIDTH ($bits(trace_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (accept),
    .in_rdy  (fifo_rdy),
    .in_dat  (rec),
    .out_vld (trace_valid_o),
    .out_rdy (trace_ready_i),
    .out_dat (head),
    .count   (count_o)
  );

  assign trace_kind_o  = head.kind;
  assign trace_pc_o    = head.pc;
  assign trace_instr_o = head.instr;
  assign trace_rd_o    = head.rd;
  assign trace_data_o  = head.data;
  assign trace_addr_o  = head.addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  // End-of-test is checked before the watchdog so it wins a same-cycle tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      done_o <= 1'b0;
`ifdef COMMIT_TRACE_WATCHDOG_EN
      timeout_o <= 1'b0;
      wdog      <= '0;
`endif
    end else if (state == ST_RUN) begin
      if (accept && (instr_i == END_INSTR)) begin
        state  <= ST_DONE;
        done_o <= 1'b1;
      end
`ifdef COMMIT_TRACE_WATCHDOG_EN
      else if (wdog == WD_LAST) begin
        state     <= ST_TIMEOUT;
        timeout_o <= 1'b1;
      end
      wdog <= wdog + 1'b1;
`endif
    end
  end

`ifndef COMMIT_TRACE_WATCHDOG_EN
  assign timeout_o = 1'b0;
`endif
endmodule
